// File: rtl/if_id_hazard_ctrl_if.sv
// Signal bundle between the IF/ID hazard controller and the front-end pipeline.
// The controller takes the slave view; the pipeline (or a bench) takes the master view.
interface if_id_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             PCSrc;
    logic             MemRead_EX;
    logic [4:0]       RD_EX;
    logic [4:0]       RS1_ID;
    logic [4:0]       RS2_ID;
    logic             imem_ready;
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  PCSrc, MemRead_EX, RD_EX, RS1_ID, RS2_ID, imem_ready,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
        output ctrl_state, stall_cnt, flush_cnt
    );

    modport master (
        output PCSrc, MemRead_EX, RD_EX, RS1_ID, RS2_ID, imem_ready,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
        input  ctrl_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// Front-end pipeline controller: sequences PC/IF-ID enables for load-use stalls,
// taken-branch flushes and instruction-memory waits, plus saturating perf counters.
module if_id_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    if_id_hazard_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        IMEM_WAIT  = 2'd2,
        FLUSH      = 2'd3
    } state_e;

    localparam logic [1:0]       FL_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [1:0]       fl_rem_q, fl_rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;

    assign lu = bus.MemRead_EX && (bus.RD_EX != 5'd0) &&
                ((bus.RD_EX == bus.RS1_ID) || (bus.RD_EX == bus.RS2_ID));

    // NOTE: every output of this block is given a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        fl_rem_d     = fl_rem_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;

        if (bus.PCSrc) begin
            // PC still advances so the branch target is captured even during a memory wait.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            fl_rem_d     = FL_INIT;
            if (FLUSH_CYCLES > 1)
                state_d = FLUSH;
            else
                state_d = bus.imem_ready ? RUN : IMEM_WAIT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = LOAD_STALL;
                    end else if (!bus.imem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = IMEM_WAIT;
                    end
                end
                LOAD_STALL: begin
                    // The load has left EX by now, so lu is stale here and deliberately ignored.
                    if (!bus.imem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = IMEM_WAIT;
                    end else begin
                        state_d = RUN;
                    end
                end
                IMEM_WAIT: begin
                    if (!bus.imem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    fl_rem_d     = fl_rem_q - 2'd1;
                    if (fl_rem_q <= 2'd1)
                        state_d = bus.imem_ready ? RUN : IMEM_WAIT;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (bus.PCSrc && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            fl_rem_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fl_rem_q    <= fl_rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.PC_write     = pc_write;
    assign bus.IF_ID_write  = if_id_write;
    assign bus.IF_ID_flush  = if_id_flush;
    assign bus.ID_EX_bubble = id_ex_bubble;
    assign bus.ctrl_state   = state_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule
